// File: rtl/sevenseg_scan_pkg.sv
// Shared constants and types for the four-digit seven-segment scan driver.
package sevenseg_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    // Pins are active-low, so "all off" means all ones
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Glyph used for a suppressed leading zero (segments a..g dark)
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    // Active-low gfedcba patterns, index = nibble; lowercase b and d
    localparam logic [15:0][6:0] HEX_GLYPHS = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    typedef enum logic {
        StBlank,
        StDrive
    } scan_state_e;

endpackage

// File: rtl/sevenseg_scan_dec.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg_dec
    import sevenseg_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup; every nibble value has a glyph
    always_comb begin
        seg_o = HEX_GLYPHS[nibble_i];
    end

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed seven-segment scan driver with frame-coherent capture,
// per-slot blanking, leading-zero suppression and decimal points.
module sevenseg_scan
    import sevenseg_scan_pkg::*;
#(
    parameter int unsigned PRESCALE_BITS = 16,
    parameter int unsigned BLANK_CYCLES  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam logic [PRESCALE_BITS-1:0] CntMax   = '1;
    localparam logic [PRESCALE_BITS-1:0] BlankCnt = PRESCALE_BITS'(BLANK_CYCLES);
    // With no blank interval the BLANK state is never shown on the pins
    localparam bit HasBlank = (BLANK_CYCLES != 0);

    logic [PRESCALE_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]               digit_q, digit_d;
    scan_state_e              state_q, state_d;
    logic [15:0]              val_q, val_d;
    logic [3:0]               dp_q, dp_d;
    logic                     lz_q, lz_d;
    logic [3:0]               an_q, an_d;
    logic [7:0]               seg_q, seg_d;
    logic                     tick_q, tick_d;

    logic [3:0]               nibble;
    logic [6:0]               glyph;
    logic                     suppress;

    // Slot counter, digit index, blank/drive state and frame capture
    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        state_d = state_q;
        val_d   = val_q;
        dp_d    = dp_q;
        lz_d    = lz_q;
        if (!enable) begin
            cnt_d   = '0;
            digit_d = '0;
            state_d = StBlank;
        end else begin
            // Start of digit 0 is the only point where a new frame is latched;
            // this also covers the first cycle after reset or enable rise.
            if (cnt_q == '0 && digit_q == '0) begin
                val_d = value;
                dp_d  = dp;
                lz_d  = lz_blank;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntMax) begin
                digit_d = digit_q + 2'd1;
            end
            unique case (state_q)
                StBlank: if (!HasBlank || cnt_d >= BlankCnt) state_d = StDrive;
                StDrive: if (HasBlank && cnt_d == '0) state_d = StBlank;
                default: state_d = StBlank;
            endcase
        end
    end

    // Select the current digit's nibble from the (possibly just captured) shadow
    always_comb begin
        nibble = val_d[{digit_q, 2'b00} +: 4];
        unique case (digit_q)
            2'd3:    suppress = lz_d && (val_d[15:12] == 4'h0);
            2'd2:    suppress = lz_d && (val_d[15:8] == 8'h00);
            2'd1:    suppress = lz_d && (val_d[15:4] == 12'h000);
            default: suppress = 1'b0;
        endcase
    end

    hex7seg_dec u_dec (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    // Registered pin values, one cycle behind the counter
    always_comb begin
        an_d   = AN_OFF;
        seg_d  = SEG_OFF;
        tick_d = 1'b0;
        if (enable && !(HasBlank && state_q == StBlank)) begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = {~dp_d[digit_q], (suppress ? GLYPH_BLANK : glyph)};
        end
        tick_d = enable && (digit_q == 2'd3) && (cnt_q == CntMax);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            digit_q <= '0;
            state_q <= StBlank;
            val_q   <= 16'h0000;
            dp_q    <= 4'h0;
            lz_q    <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            state_q <= state_d;
            val_q   <= val_d;
            dp_q    <= dp_d;
            lz_q    <= lz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench: two scan drivers (2 blank cycles and none) against a frame-level model.
module tb_sevenseg_scan;

    logic        clk = 1'b0;
    logic        reset, enable, lz_blank;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  an, an0;
    logic [7:0]  seg, seg0;
    logic        frame_tick, ft0;

    int checks = 0;
    int errors = 0;

    // Model state: enabled cycles since scan start and the frame's captured inputs
    int          k = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic        m_lz = 1'b0;
    logic [12:0] exp_a, exp_b;
    localparam logic [12:0] OFF = {4'hF, 8'hFF, 1'b0};

    always #5 clk = ~clk;

    sevenseg_scan #(.PRESCALE_BITS(4), .BLANK_CYCLES(2)) dut (
        .clk (clk), .reset (reset), .enable (enable), .value (value), .dp (dp),
        .lz_blank (lz_blank), .an (an), .seg (seg), .frame_tick (frame_tick)
    );

    sevenseg_scan #(.PRESCALE_BITS(4), .BLANK_CYCLES(0)) dut0 (
        .clk (clk), .reset (reset), .enable (enable), .value (value), .dp (dp),
        .lz_blank (lz_blank), .an (an0), .seg (seg0), .frame_tick (ft0)
    );

    // Lit segments (active-high gfedcba) of each hex glyph
    function automatic logic [6:0] lit(input logic [3:0] n);
        case (n)
            4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
        endcase
    endfunction

    // Expected {an, seg, frame_tick} for the kk-th enabled cycle
    function automatic logic [12:0] model_out(input int kk, input int blank);
        int          pos, d;
        logic [15:0] upper;
        logic [3:0]  a;
        logic [6:0]  s;
        pos = kk % 16;
        d   = (kk / 16) % 4;
        if (pos < blank) return OFF;
        a     = 4'hF ^ (4'b0001 << d);
        upper = m_val >> (4 * d);
        if (m_lz && d != 0 && upper == 16'h0) s = 7'h7F;
        else s = ~lit(upper[3:0]);
        return {a, ~m_dp[d], s, (kk % 64 == 63)};
    endfunction

    // Advance one clock and update the model expectations; sample 1 time unit later
    task automatic step();
        @(posedge clk);
        if (reset || !enable) begin
            k = 0;
            exp_a = OFF;
            exp_b = OFF;
        end else begin
            if (k % 64 == 0) begin
                m_val = value;
                m_dp  = dp;
                m_lz  = lz_blank;
            end
            exp_a = model_out(k, 2);
            exp_b = model_out(k, 0);
            k++;
        end
        #1;
    endtask

    task automatic align();
        while (k % 64 != 0) step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({an, seg, frame_tick} !== OFF) begin
                errors++;
                $display("FAIL reset_vals got %h want %h", {an, seg, frame_tick}, OFF);
            end
            checks++;
            if ({an0, seg0, ft0} !== OFF) begin
                errors++;
                $display("FAIL reset_vals_b0 got %h want %h", {an0, seg0, ft0}, OFF);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_scan_random();
        int ticks = 0;
        align();
        for (int f = 0; f < 4; f++) begin
            value = 16'($urandom); dp = 4'($urandom); lz_blank = 1'($urandom);
            if (f == 0) value = 16'h1234;
            for (int i = 0; i < 64; i++) begin
                // Mid-frame input churn must not reach the pins
                if (i == 23 || i == 41) begin
                    value = 16'($urandom); dp = 4'($urandom); lz_blank = 1'($urandom);
                end
                step();
                ticks += int'(frame_tick);
                checks++;
                if ({an, seg, frame_tick} !== exp_a) begin
                    errors++;
                    $display("FAIL scan k=%0d got %h want %h", k, {an, seg, frame_tick}, exp_a);
                end
                checks++;
                if ({an0, seg0, ft0} !== exp_b) begin
                    errors++;
                    $display("FAIL scan_b0 k=%0d got %h want %h", k, {an0, seg0, ft0}, exp_b);
                end
            end
        end
        checks++;
        if (ticks != 4) begin
            errors++;
            $display("FAIL tick_count got %0d want 4", ticks);
        end
    endtask

    task automatic test_lz();
        align();
        dp = 4'h0;
        for (int f = 0; f < 2; f++) begin
            value = 16'h0007; lz_blank = (f == 0);
            for (int i = 0; i < 64; i++) begin
                step();
                checks++;
                if ({an, seg, frame_tick} !== exp_a) begin
                    errors++;
                    $display("FAIL lz k=%0d got %h want %h", k, {an, seg, frame_tick}, exp_a);
                end
                if (i == 53) begin
                    checks++;
                    if ({an, seg} !== (f == 0 ? 12'h7FF : 12'h7C0)) begin
                        errors++;
                        $display("FAIL lz_digit3 f=%0d got %h", f, {an, seg});
                    end
                end
                if (i == 8) begin
                    checks++;
                    if ({an, seg} !== 12'hEF8) begin
                        errors++;
                        $display("FAIL lz_digit0 got %h want EF8", {an, seg});
                    end
                end
            end
        end
    endtask

    task automatic test_dp_zero();
        align();
        value = 16'h0000; dp = 4'b0100; lz_blank = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if ({an0, seg0, ft0} !== exp_b) begin
                errors++;
                $display("FAIL dpzero k=%0d got %h want %h", k, {an0, seg0, ft0}, exp_b);
            end
            if (i == 40 || i == 8 || i == 56 || i == 24) begin
                checks++;
                if (seg !== (i == 40 ? 8'h7F : (i == 8 ? 8'hC0 : 8'hFF))) begin
                    errors++;
                    $display("FAIL dpzero_seg i=%0d got %h", i, seg);
                end
            end
        end
    endtask

    task automatic test_midframe();
        align();
        value = 16'hAAAA; dp = 4'h0; lz_blank = 1'b0;
        for (int i = 0; i < 128; i++) begin
            if (i == 20) value = 16'h5555;
            step();
            checks++;
            if ({an, seg, frame_tick} !== exp_a) begin
                errors++;
                $display("FAIL midframe k=%0d got %h want %h", k, {an, seg, frame_tick}, exp_a);
            end
            if (i == 40 || i == 72) begin
                checks++;
                if (seg !== (i == 40 ? 8'h88 : 8'h92)) begin
                    errors++;
                    $display("FAIL midframe_seg i=%0d got %h", i, seg);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        align();
        value = 16'h00F0; dp = 4'b1001; lz_blank = 1'b1;
        for (int i = 0; i < 36; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({an, seg, frame_tick} !== OFF || {an0, seg0, ft0} !== OFF) begin
                errors++;
                $display("FAIL enable_off got %h %h want %h", {an, seg, frame_tick},
                         {an0, seg0, ft0}, OFF);
            end
        end
        value = 16'h1234; dp = 4'h0; lz_blank = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if ({an, seg, frame_tick} !== exp_a) begin
                errors++;
                $display("FAIL reenable k=%0d got %h want %h", k, {an, seg, frame_tick}, exp_a);
            end
            if (i == 2) begin
                checks++;
                if ({an, seg} !== 12'hE99) begin
                    errors++;
                    $display("FAIL reenable_first got %h want E99", {an, seg});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int active = 0;
        align();
        value = 16'($urandom); dp = 4'($urandom); lz_blank = 1'b0;
        for (int i = 0; i < 20; i++) step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({an, seg, frame_tick} !== OFF || {an0, seg0, ft0} !== OFF) begin
            errors++;
            $display("FAIL async_reset got %h %h want %h", {an, seg, frame_tick},
                     {an0, seg0, ft0}, OFF);
        end
        step();
        step();
        reset = 1'b0;
        value = 16'hC0DE;
        for (int i = 0; i < 64; i++) begin
            step();
            if (i < 16) active += int'(an0 != 4'hF);
            checks++;
            if ({an0, seg0, ft0} !== exp_b) begin
                errors++;
                $display("FAIL post_reset_b0 k=%0d got %h want %h", k, {an0, seg0, ft0}, exp_b);
            end
        end
        checks++;
        if (active != 16) begin
            errors++;
            $display("FAIL noblank_active got %0d want 16", active);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; value = 16'h0; dp = 4'h0; lz_blank = 1'b0;
        #1 reset = 1'b1;
        test_reset();
        test_scan_random();
        test_lz();
        test_dp_zero();
        test_midframe();
        test_enable_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
